// File: rtl/lvds_link_pkg.sv
// Shared LVDS link definitions: frame geometry, keepalive tag and frame helpers
// used by the TX scheduler and the RX-side demux.
package lvds_link_pkg;

    localparam int NB   = 42;
    localparam int TAGW = 3;
    localparam int PW   = NB - TAGW;

    localparam logic [TAGW-1:0] KA_TAG = {TAGW{1'b1}};

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [PW-1:0]   payload;
    } frame_t;

    // Cycles needed to shift an nb+1 bit frame at 4 bits per cycle.
    function automatic int gap_cycles(input int nb);
        return (nb + 4) / 4;
    endfunction

    function automatic logic [NB-1:0] pack_frame(input logic [TAGW-1:0] tag,
                                                 input logic [PW-1:0]   payload);
        return {tag, payload};
    endfunction

    function automatic frame_t unpack_frame(input logic [NB-1:0] d);
        return frame_t'(d);
    endfunction

endpackage

// File: rtl/lvds_tx_sched_rr_arb.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps mod N,
// returning a one-hot grant plus the index of the winner.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] j;

    always_comb begin
        gnt     = '0;
        any     = 1'b0;
        gnt_idx = '0;
        j       = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = j;
            end
        end
    end

endmodule

// File: rtl/lvds_tx_sched.sv
// Frame scheduler feeding lvds_tx: round-robin sharing of one link, frame pacing
// so each frame fully shifts out, and keepalive insertion on an idle link.
module lvds_tx_sched
    import lvds_link_pkg::*;
#(
    parameter int NB   = lvds_link_pkg::NB,
    parameter int NREQ = 4,
    parameter int TAGW = lvds_link_pkg::TAGW,
    parameter int GAP  = gap_cycles(NB),
    parameter int KA   = 1024
) (
    input  logic                       c,
    input  logic                       rn,
    input  logic                       en,
    input  logic [NREQ-1:0]            req_v,
    input  logic [NREQ*(NB-TAGW)-1:0]  req_d,
    output logic [NREQ-1:0]            req_ack,
    output logic                       tx_v,
    output logic [NB-1:0]              tx_d,
    output logic [15:0]                ka_seq
);

    localparam int PW   = NB - TAGW;
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GCW  = $clog2(GAP);
    localparam int ICW  = $clog2(KA);

    localparam logic [GCW-1:0]  GC_RELOAD = GCW'(GAP - 1);
    localparam logic [ICW-1:0]  IC_MAX    = ICW'(KA - 1);
    localparam logic [TAGW-1:0] KA_TAG_W  = {TAGW{1'b1}};

    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [GCW-1:0]  gc_q, gc_d;
    logic [ICW-1:0]  ic_q, ic_d;
    logic            tx_v_q, tx_v_d;
    logic [NB-1:0]   tx_d_q, tx_d_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic [15:0]     ka_seq_q, ka_seq_d;

    logic [NREQ-1:0] gnt;
    logic            any;
    logic [PTRW-1:0] gnt_idx;
    logic [PW-1:0]   payload;
    logic            slot_open;
    logic            ka_due;
    logic            issue;

    rr_arb #(
        .N  (NREQ),
        .IW (PTRW)
    ) u_arb (
        .req     (req_v),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .any     (any),
        .gnt_idx (gnt_idx)
    );

    assign slot_open = en && (gc_q == '0);
    assign ka_due    = (ic_q == IC_MAX);
    assign issue     = slot_open && (ka_due || any);

    always_comb begin
        payload = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) payload = req_d[i*PW +: PW];
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        gc_d      = (gc_q == '0) ? '0 : gc_q - 1'b1;
        ic_d      = ic_q;
        tx_v_d    = 1'b0;
        tx_d_d    = tx_d_q;
        req_ack_d = '0;
        ka_seq_d  = ka_seq_q;

        if (issue) begin
            tx_v_d = 1'b1;
            gc_d   = GC_RELOAD;
            ic_d   = '0;
            // A due keepalive preempts requesters and leaves the rr pointer alone.
            if (ka_due) begin
                tx_d_d   = {KA_TAG_W, PW'(ka_seq_q)};
                ka_seq_d = ka_seq_q + 16'd1;
            end else begin
                tx_d_d    = {TAGW'(gnt_idx), payload};
                req_ack_d = gnt;
                ptr_d     = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            end
        end else if (slot_open && !ka_due) begin
            // Idle time is counted in open slots only, so a frame gap never
            // eats into the keepalive interval.
            ic_d = ic_q + 1'b1;
        end
    end

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            ptr_q     <= '0;
            gc_q      <= '0;
            ic_q      <= '0;
            tx_v_q    <= 1'b0;
            tx_d_q    <= '0;
            req_ack_q <= '0;
            ka_seq_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            gc_q      <= gc_d;
            ic_q      <= ic_d;
            tx_v_q    <= tx_v_d;
            tx_d_q    <= tx_d_d;
            req_ack_q <= req_ack_d;
            ka_seq_q  <= ka_seq_d;
        end
    end

    assign tx_v    = tx_v_q;
    assign tx_d    = tx_d_q;
    assign req_ack = req_ack_q;
    assign ka_seq  = ka_seq_q;

endmodule

// File: tb/tb_lvds_tx_sched.sv
// Directed bench for lvds_tx_sched: arbitration order, pacing, keepalive
// timing, keepalive priority, asynchronous reset and link-enable gating.
module tb_lvds_tx_sched;

    localparam int NB   = 42;
    localparam int NREQ = 4;
    localparam int TAGW = 3;
    localparam int PW   = NB - TAGW;

    logic                 c;
    logic                 rn;
    logic                 en;
    logic [NREQ-1:0]      req_v;
    logic [NREQ*PW-1:0]   req_d;
    logic [NREQ-1:0]      req_ack;
    logic                 tx_v;
    logic [NB-1:0]        tx_d;
    logic [15:0]          ka_seq;

    int tests_run = 0;
    int fails     = 0;

    lvds_tx_sched #(
        .NB   (NB),
        .NREQ (NREQ),
        .TAGW (TAGW),
        .GAP  (11),
        .KA   (1024)
    ) dut (
        .c       (c),
        .rn      (rn),
        .en      (en),
        .req_v   (req_v),
        .req_d   (req_d),
        .req_ack (req_ack),
        .tx_v    (tx_v),
        .tx_d    (tx_d),
        .ka_seq  (ka_seq)
    );

    // clock / reset
    initial c = 1'b0;
    always #5 c = ~c;

    // driver tasks
    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic tick_n(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            tick();
            if (tx_v) pulses++;
        end
    endtask

    task automatic set_pay(input int i, input logic [PW-1:0] p);
        req_d[i*PW +: PW] = p;
    endtask

    task automatic apply_reset();
        rn    = 1'b0;
        en    = 1'b0;
        req_v = '0;
        req_d = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++; if (tx_v !== 1'b0) begin fails++; $display("FAIL rst_tx_v: got %0h want 0", tx_v); end
        tests_run++; if (tx_d !== '0) begin fails++; $display("FAIL rst_tx_d: got %0h want 0", tx_d); end
        tests_run++; if (req_ack !== 4'b0000) begin fails++; $display("FAIL rst_ack: got %b want 0000", req_ack); end
        tests_run++; if (ka_seq !== 16'd0) begin fails++; $display("FAIL rst_ka_seq: got %0d want 0", ka_seq); end
    endtask

    task automatic test_single();
        apply_reset();
        rn    = 1'b1;
        en    = 1'b1;
        req_v = 4'b0001;
        set_pay(0, 39'h1234);
        tick();
        tests_run++; if (tx_v !== 1'b1) begin fails++; $display("FAIL single_tx_v: got %0h want 1", tx_v); end
        tests_run++; if (tx_d !== {3'd0, 39'h1234}) begin fails++; $display("FAIL single_tx_d: got %0h want %0h", tx_d, {3'd0, 39'h1234}); end
        tests_run++; if (req_ack !== 4'b0001) begin fails++; $display("FAIL single_ack: got %b want 0001", req_ack); end
        req_v = 4'b0000;
        tick();
        tests_run++; if (tx_v !== 1'b0) begin fails++; $display("FAIL single_tx_v_drop: got %0h want 0", tx_v); end
        tests_run++; if (req_ack !== 4'b0000) begin fails++; $display("FAIL single_ack_pulse: got %b want 0000", req_ack); end
        tests_run++; if (tx_d !== {3'd0, 39'h1234}) begin fails++; $display("FAIL single_tx_d_hold: got %0h want %0h", tx_d, {3'd0, 39'h1234}); end
    endtask

    task automatic test_back_to_back();
        int seen;
        int cyc;
        int last;
        logic [2:0]    et;
        logic [PW-1:0] ep;
        apply_reset();
        rn    = 1'b1;
        en    = 1'b1;
        for (int i = 0; i < NREQ; i++) set_pay(i, 39'h0123456700 + 39'(i));
        req_v = 4'b1111;
        seen  = 0;
        cyc   = 0;
        last  = 0;
        while (seen < 8 && cyc < 200) begin
            tick();
            cyc++;
            if (tx_v) begin
                et = 3'(seen % 4);
                ep = 39'h0123456700 + 39'(seen % 4);
                tests_run++; if (tx_d !== {et, ep}) begin fails++; $display("FAIL b2b_tx_d[%0d]: got %0h want %0h", seen, tx_d, {et, ep}); end
                tests_run++; if (req_ack !== (4'b0001 << et)) begin fails++; $display("FAIL b2b_ack[%0d]: got %b want %b", seen, req_ack, 4'b0001 << et); end
                if (seen > 0) begin
                    tests_run++; if (cyc - last !== 11) begin fails++; $display("FAIL b2b_gap[%0d]: got %0d want 11", seen, cyc - last); end
                end
                last = cyc;
                seen++;
            end
        end
        tests_run++; if (seen !== 8) begin fails++; $display("FAIL b2b_count: got %0d want 8", seen); end
        req_v = 4'b0000;
    endtask

    task automatic test_keepalive();
        int p;
        apply_reset();
        rn = 1'b1;
        en = 1'b1;
        tick_n(1023, p);
        tests_run++; if (p !== 0) begin fails++; $display("FAIL ka_early: got %0d pulses want 0", p); end
        tick();
        tests_run++; if (tx_v !== 1'b1) begin fails++; $display("FAIL ka1_tx_v: got %0h want 1", tx_v); end
        tests_run++; if (tx_d !== {3'b111, 39'd0}) begin fails++; $display("FAIL ka1_tx_d: got %0h want %0h", tx_d, {3'b111, 39'd0}); end
        tests_run++; if (ka_seq !== 16'd1) begin fails++; $display("FAIL ka1_seq: got %0d want 1", ka_seq); end
        tests_run++; if (req_ack !== 4'b0000) begin fails++; $display("FAIL ka1_ack: got %b want 0000", req_ack); end
        tick_n(1033, p);
        tests_run++; if (p !== 0) begin fails++; $display("FAIL ka2_early: got %0d pulses want 0", p); end
        tick();
        tests_run++; if (tx_v !== 1'b1) begin fails++; $display("FAIL ka2_tx_v: got %0h want 1", tx_v); end
        tests_run++; if (tx_d !== {3'b111, 39'd1}) begin fails++; $display("FAIL ka2_tx_d: got %0h want %0h", tx_d, {3'b111, 39'd1}); end
        tests_run++; if (ka_seq !== 16'd2) begin fails++; $display("FAIL ka2_seq: got %0d want 2", ka_seq); end
    endtask

    // Runs straight after test_keepalive: gc is counting down with ka_seq=2.
    task automatic test_reset_mid_gap();
        int p;
        req_v = 4'b0010;
        set_pay(1, 39'h5555555555);
        tick_n(5, p);
        tests_run++; if (p !== 0) begin fails++; $display("FAIL mid_gap_pulse: got %0d want 0", p); end
        #1 rn = 1'b0;
        #1;
        tests_run++; if (ka_seq !== 16'd0) begin fails++; $display("FAIL mid_rst_seq: got %0d want 0", ka_seq); end
        tests_run++; if (tx_d !== '0) begin fails++; $display("FAIL mid_rst_tx_d: got %0h want 0", tx_d); end
        tests_run++; if (tx_v !== 1'b0 || req_ack !== 4'b0000) begin fails++; $display("FAIL mid_rst_v_ack: got %0h/%b want 0/0000", tx_v, req_ack); end
        tick();
        tick();
        tests_run++; if (tx_v !== 1'b0 || ka_seq !== 16'd0) begin fails++; $display("FAIL mid_rst_held: got %0h/%0d want 0/0", tx_v, ka_seq); end
        rn = 1'b1;
        tick();
        tests_run++; if (tx_v !== 1'b1) begin fails++; $display("FAIL mid_rel_tx_v: got %0h want 1", tx_v); end
        tests_run++; if (tx_d !== {3'd1, 39'h5555555555}) begin fails++; $display("FAIL mid_rel_tx_d: got %0h want %0h", tx_d, {3'd1, 39'h5555555555}); end
        tests_run++; if (req_ack !== 4'b0010) begin fails++; $display("FAIL mid_rel_ack: got %b want 0010", req_ack); end
        req_v = 4'b0000;
    endtask

    task automatic test_ka_priority();
        int p;
        apply_reset();
        rn    = 1'b1;
        en    = 1'b1;
        req_v = 4'b0010;
        set_pay(1, 39'h11);
        tick();
        tests_run++; if (tx_d !== {3'd1, 39'h11} || tx_v !== 1'b1) begin fails++; $display("FAIL kap_first: got %0h/%0h want 1/%0h", tx_v, tx_d, {3'd1, 39'h11}); end
        req_v = 4'b0000;
        tick_n(1033, p);
        tests_run++; if (p !== 0) begin fails++; $display("FAIL kap_idle: got %0d pulses want 0", p); end
        set_pay(0, 39'h0A0A);
        set_pay(2, 39'h2B2B);
        req_v = 4'b0101;
        tick();
        tests_run++; if (tx_v !== 1'b1 || tx_d !== {3'b111, 39'd0}) begin fails++; $display("FAIL kap_ka: got %0h/%0h want 1/%0h", tx_v, tx_d, {3'b111, 39'd0}); end
        tests_run++; if (req_ack !== 4'b0000 || ka_seq !== 16'd1) begin fails++; $display("FAIL kap_ka_ack_seq: got %b/%0d want 0000/1", req_ack, ka_seq); end
        tick_n(10, p);
        tests_run++; if (p !== 0) begin fails++; $display("FAIL kap_gap1: got %0d pulses want 0", p); end
        tick();
        tests_run++; if (tx_v !== 1'b1 || tx_d !== {3'd2, 39'h2B2B}) begin fails++; $display("FAIL kap_req2: got %0h/%0h want 1/%0h", tx_v, tx_d, {3'd2, 39'h2B2B}); end
        tests_run++; if (req_ack !== 4'b0100) begin fails++; $display("FAIL kap_req2_ack: got %b want 0100", req_ack); end
        req_v = 4'b0001;
        tick_n(10, p);
        tests_run++; if (p !== 0) begin fails++; $display("FAIL kap_gap2: got %0d pulses want 0", p); end
        tick();
        tests_run++; if (tx_v !== 1'b1 || tx_d !== {3'd0, 39'h0A0A} || req_ack !== 4'b0001) begin fails++; $display("FAIL kap_req0: got %0h/%0h/%b want 1/%0h/0001", tx_v, tx_d, req_ack, {3'd0, 39'h0A0A}); end
        req_v = 4'b0000;
    endtask

    task automatic test_en_gate();
        int p;
        int p2;
        apply_reset();
        rn = 1'b1;
        en = 1'b1;
        tick_n(500, p);
        en    = 1'b0;
        set_pay(2, 39'h77);
        req_v = 4'b0100;
        tick_n(1000, p2);
        req_v = 4'b0000;
        p = p + p2;
        tick_n(1000, p2);
        tests_run++; if (p + p2 !== 0) begin fails++; $display("FAIL en_off_pulses: got %0d want 0", p + p2); end
        en = 1'b1;
        tick_n(523, p);
        tests_run++; if (p !== 0) begin fails++; $display("FAIL en_resume_early: got %0d pulses want 0", p); end
        tick();
        tests_run++; if (tx_v !== 1'b1 || tx_d !== {3'b111, 39'd0}) begin fails++; $display("FAIL en_resume_ka: got %0h/%0h want 1/%0h", tx_v, tx_d, {3'b111, 39'd0}); end
        tests_run++; if (ka_seq !== 16'd1) begin fails++; $display("FAIL en_resume_seq: got %0d want 1", ka_seq); end
    endtask

    initial begin
        rn    = 1'b0;
        en    = 1'b0;
        req_v = '0;
        req_d = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_keepalive();
        test_reset_mid_gap();
        test_ka_priority();
        test_en_gate();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
